// File: rtl/mux_pkg.sv
// ----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the stream_mux_rr block.
//   MODE_SEL / MODE_RR : encodings of the mode input
//   clog2()            : ceiling log2 used to size select/channel-id fields
// ----------------------------------------------------------------------------
package mux_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   // Smallest r with (1 << r) >= n. Returns 0 for n <= 1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational rotating-priority scan. Starting at ptr+1 and wrapping modulo
// NCH, it returns the first requesting channel. The pointer register itself
// is owned by the caller.
//   req     : per-channel request
//   ptr     : last granted channel (scan starts just after it)
//   gnt_idx : index of the granted channel (0 when gnt_any = 0)
//   gnt_any : at least one channel is requesting
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NCH  = 3,
   parameter int SELW = 2
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic [SELW-1:0] gnt_idx,
   output logic            gnt_any
);

   // w_idx[k] is the channel examined at scan position k; w_rot is the
   // request vector rotated so that position 0 has the highest priority.
   logic [SELW-1:0] w_idx [NCH];
   logic [NCH-1:0]  w_rot;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_rot
         assign w_idx[gi] = SELW'((int'(ptr) + 1 + gi) % NCH);
         assign w_rot[gi] = req[w_idx[gi]];
      end
   endgenerate

   // Scan from the lowest priority upwards so the highest-priority hit
   // (smallest scan position) is the last to write the result.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            gnt_any = 1'b1;
            gnt_idx = w_idx[k];
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// ----------------------------------------------------------------------------
// stream_mux_rr
// N-channel valid/ready selector with a single registered output stage.
// In explicit-select mode sel picks the channel; in round-robin mode the
// channels are served in rotating priority order.
//   clk, reset          : clock, asynchronous active-high reset
//   mode                : 0 = explicit select, 1 = round-robin
//   sel                 : channel index for explicit select mode
//   in_data/in_valid    : flattened channel data, per-channel valid
//   in_ready            : per-channel ready (combinational)
//   out_data/out_ch     : registered selected word and its source channel
//   out_valid/out_ready : output handshake
//   sel_err             : sticky, set when an out-of-range sel is presented
// ----------------------------------------------------------------------------
module stream_mux_rr
   import mux_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int NCH   = 3,
   localparam int SELW  = clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 sel_err
);

   logic [WIDTH-1:0] r_out_data;
   logic [SELW-1:0]  r_out_ch;
   logic             r_out_valid;
   logic             r_sel_err;
   logic [SELW-1:0]  r_rr_ptr;

   logic             w_load_en;
   logic             w_sel_ok;
   logic [SELW-1:0]  w_arb_idx;
   logic             w_arb_any;
   logic [SELW-1:0]  w_g;
   logic             w_gnt_any;
   logic             w_xfer;
   logic [WIDTH-1:0] w_sel_data;

   // The output register can take a new word when it is empty or is being
   // drained this very cycle.
   assign w_load_en = !r_out_valid || out_ready;
   assign w_sel_ok  = (int'(sel) < NCH);

   rr_arbiter #(
      .NCH  (NCH),
      .SELW (SELW)
   ) u_arb (
      .req     (in_valid),
      .ptr     (r_rr_ptr),
      .gnt_idx (w_arb_idx),
      .gnt_any (w_arb_any)
   );

   // In select mode the grant ignores in_valid; an out-of-range sel grants
   // nothing.
   always_comb begin
      w_g       = '0;
      w_gnt_any = 1'b0;
      if (mode == MODE_SEL) begin
         w_g       = sel;
         w_gnt_any = w_sel_ok;
      end else begin
         w_g       = w_arb_idx;
         w_gnt_any = w_arb_any;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_rdy
         assign in_ready[gi] = w_gnt_any && w_load_en && (w_g == SELW'(gi));
      end
   endgenerate

   assign w_xfer = |(in_valid & in_ready);

   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_g == SELW'(i)) begin
            w_sel_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_out_valid <= 1'b0;
         r_sel_err   <= 1'b0;
         r_rr_ptr    <= SELW'(NCH - 1);   // channel 0 scanned first
      end else begin
         if (w_xfer) begin
            r_out_data  <= w_sel_data;
            r_out_ch    <= w_g;
            r_out_valid <= 1'b1;
            if (mode == MODE_RR) begin
               r_rr_ptr <= w_g;
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
         if ((mode == MODE_SEL) && !w_sel_ok) begin
            r_sel_err <= 1'b1;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;
   assign out_valid = r_out_valid;
   assign sel_err   = r_sel_err;

endmodule
